// File: rtl/pulse_level_stretcher_if.sv
// Event/level bundle for pulse_level_stretcher.
// The stimulus side uses the master modport and the stretcher uses the slave modport.
interface pulse_level_stretcher_if #(
  parameter int PEND_W = 3
);
  logic              PulseIn;
  logic              ClearOverflow;
  logic              LevelOut;
  logic              Busy;
  logic [PEND_W-1:0] PendingCount;
  logic              Overflow;

  modport master (
    output PulseIn, ClearOverflow,
    input  LevelOut, Busy, PendingCount, Overflow
  );

  modport slave (
    input  PulseIn, ClearOverflow,
    output LevelOut, Busy, PendingCount, Overflow
  );
endinterface

// File: rtl/pulse_level_stretcher.sv
// Stretches single-cycle event strobes into ON_CYCLES-wide level pulses with a
// GAP_CYCLES low gap after each one; events that arrive while busy are queued and replayed in order.
module pulse_level_stretcher #(
  parameter int ON_CYCLES  = 4,
  parameter int GAP_CYCLES = 2,
  parameter int PEND_W     = 3
) (
  input  logic                      CLK,
  input  logic                      RST_N,
  pulse_level_stretcher_if.slave    bus
);

  localparam int CNT_MAX = (ON_CYCLES > GAP_CYCLES) ? ON_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0]  ON_LOAD  = CNT_W'(ON_CYCLES - 1);
  localparam logic [CNT_W-1:0]  GAP_LOAD = CNT_W'(GAP_CYCLES - 1);
  localparam logic [PEND_W-1:0] PEND_MAX = '1;
  localparam logic [PEND_W-1:0] PEND_ONE = PEND_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [PEND_W-1:0] pend, pend_nxt;
  logic              overflow, overflow_nxt;
  logic              level_q, busy_q;
  logic              consumed;
  logic              drop;

  // NOTE: every variable written here gets a default first so no path leaves one unassigned, which would infer a latch.
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    pend_nxt     = pend;
    overflow_nxt = overflow;
    consumed     = 1'b0;
    drop         = 1'b0;

    unique case (state)
      IDLE: begin
        if (bus.PulseIn) begin
          state_nxt = ON;
          cnt_nxt   = ON_LOAD;
          consumed  = 1'b1;
        end
      end

      ON: begin
        if (cnt != '0) begin
          cnt_nxt = cnt - CNT_ONE;
        end else begin
          state_nxt = GAP;
          cnt_nxt   = GAP_LOAD;
        end
      end

      GAP: begin
        if (cnt != '0) begin
          cnt_nxt = cnt - CNT_ONE;
        end else if (pend != '0) begin
          state_nxt = ON;
          cnt_nxt   = ON_LOAD;
          // A strobe on the replay edge takes the slot the replayed event frees.
          if (bus.PulseIn) consumed = 1'b1;
          else             pend_nxt = pend - PEND_ONE;
        end else if (bus.PulseIn) begin
          state_nxt = ON;
          cnt_nxt   = ON_LOAD;
          consumed  = 1'b1;
        end else begin
          state_nxt = IDLE;
        end
      end

      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase

    if (bus.PulseIn && !consumed) begin
      if (pend != PEND_MAX) pend_nxt = pend + PEND_ONE;
      else                  drop     = 1'b1;
    end

    if (drop)                   overflow_nxt = 1'b1;
    else if (bus.ClearOverflow) overflow_nxt = 1'b0;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values regardless of block order.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state    <= IDLE;
      cnt      <= '0;
      pend     <= '0;
      overflow <= 1'b0;
      level_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      pend     <= pend_nxt;
      overflow <= overflow_nxt;
      level_q  <= (state_nxt == ON);
      busy_q   <= (state_nxt != IDLE);
    end
  end

  assign bus.LevelOut     = level_q;
  assign bus.Busy         = busy_q;
  assign bus.PendingCount = pend;
  assign bus.Overflow     = overflow;

endmodule

// File: tb/tb_pulse_level_stretcher.sv
// Directed bench for pulse_level_stretcher (ON=4, GAP=2, PEND_W=2).
// Each step drives inputs, waits one edge, and compares outputs against hand-written per-cycle strings.
module tb_pulse_level_stretcher;

  localparam int PW = 2;

  logic CLK;
  logic RST_N;
  int   checks   = 0;
  int   failures = 0;

  pulse_level_stretcher_if #(.PEND_W(PW)) bus ();

  pulse_level_stretcher #(
    .ON_CYCLES (4),
    .GAP_CYCLES(2),
    .PEND_W    (PW)
  ) dut (
    .CLK  (CLK),
    .RST_N(RST_N),
    .bus  (bus)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp)
    else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Character i of s as a digit; positions past the end read as 0.
  function automatic logic [7:0] digit(input string s, input int i);
    if (i >= s.len()) return 8'd0;
    return 8'(s[i] - 8'h30);
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic expect_all(input string tag, input logic [7:0] lvl, input logic [7:0] bsy,
                            input logic [7:0] pend, input logic [7:0] ovf);
    check({tag, ".lvl"},  8'(bus.LevelOut),     lvl);
    check({tag, ".busy"}, 8'(bus.Busy),         bsy);
    check({tag, ".pend"}, 8'(bus.PendingCount), pend);
    check({tag, ".ovf"},  8'(bus.Overflow),     ovf);
  endtask

  // One entry per clock: pin/clr are applied before edge i, the rest are expected after it.
  task automatic run(input string tag, input string pin, input string clr, input string lvl,
                     input string bsy, input string pend, input string ovf);
    for (int i = 0; i < pin.len(); i++) begin
      bus.PulseIn       = digit(pin, i)[0];
      bus.ClearOverflow = digit(clr, i)[0];
      tick();
      expect_all($sformatf("%s[%0d]", tag, i), digit(lvl, i), digit(bsy, i),
                 digit(pend, i), digit(ovf, i));
    end
    bus.PulseIn       = 1'b0;
    bus.ClearOverflow = 1'b0;
  endtask

  initial begin
    RST_N             = 1'b0;
    bus.PulseIn       = 1'b0;
    bus.ClearOverflow = 1'b0;
    #23;
    expect_all("reset", 8'd0, 8'd0, 8'd0, 8'd0);
    @(negedge CLK);
    RST_N = 1'b1;

    // Idle cycles after reset release: nothing moves.
    run("idle", "000", "", "000", "000", "000", "");

    run("single", "1000000", "", "1111000", "1111110", "", "");

    run("three",
        "1110000000000000000", "",
        "1111001111001111000",
        "1111111111111111110",
        "0122221111110000000", "");

    // Strobe on the GAP-exit edge with an empty queue starts a new pulse directly.
    run("gap_direct",
        "1000001000000", "",
        "1111001111000",
        "1111111111110",
        "", "");

    run("overflow",
        "1111100000000000000000000", "",
        "1111001111001111001111000",
        "1111111111111111111111110",
        "0123332222221111110000000",
        "0000111111111111111111111");

    run("ovf_clear", "0", "1", "0", "0", "0", "0");

    run("consume_arrive",
        "1100001000000000000", "",
        "1111001111001111000",
        "1111111111111111110",
        "0111111111110000000", "");

    // Reset mid-ON with two queued events: outputs clear before the next edge.
    run("pre_reset", "111", "", "111", "111", "012", "");
    #2;
    RST_N = 1'b0;
    #2;
    expect_all("async_reset", 8'd0, 8'd0, 8'd0, 8'd0);
    @(negedge CLK);
    RST_N = 1'b1;
    run("post_reset", "1000000", "", "1111000", "1111110", "", "");

    // Clear on the same edge as a drop loses; clear alone on the next edge wins.
    run("clr_vs_set",
        "1111100000000000000000000",
        "0000110000000000000000000",
        "1111001111001111001111000",
        "1111111111111111111111110",
        "0123332222221111110000000",
        "0000100000000000000000000");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pulse_level_stretcher.md
# pulse_level_stretcher

Converts single-cycle enable pulses (key-press strobes, sale-complete events) into fixed-width active-high level pulses for the terminal's human-facing outputs: LED, beeper or relay drivers. Each accepted input pulse yields exactly one output pulse of ON_CYCLES clocks, followed by a guaranteed low gap of GAP_CYCLES clocks. Pulses arriving while an output pulse is in progress are counted and replayed in order, up to a bounded depth.

## Interface
- ON_CYCLES, default 4: output high time in clocks; must be ≥1.
- GAP_CYCLES, default 2: minimum output low time between consecutive output pulses; must be ≥1.
- PEND_W, default 3: width of the pending counter; maximum pending is 2^PEND_W−1.

Ports:
- CLK  input  1  single system clock; all logic on posedge.
- RST_N  input  1  reset, asynchronous, active-low.
- PulseIn  input  1  synchronous event strobe; each high cycle counts as one event.
- ClearOverflow  input  1  synchronous clear of Overflow.
- LevelOut  output  1  stretched level pulse, registered.
- Busy  output  1  high whenever state ≠ IDLE.
- PendingCount  output  PEND_W  number of queued, not-yet-started events.
- Overflow  output  1  sticky flag: an event was dropped.

## Operation
- Three-state FSM: IDLE, ON, GAP. Timing counter is sized to max(ON_CYCLES, GAP_CYCLES).
- Reset (RST_N low, asynchronous): state=IDLE, LevelOut=0, Busy=0, PendingCount=0, Overflow=0, counter=0.
- **IDLE:**
  - PulseIn=1 → ON, counter=ON_CYCLES−1. The event starts immediately and is not queued.
- **ON:**
  - counter≠0 → decrement.
  - counter=0 → GAP, counter=GAP_CYCLES−1.
- **GAP:**
  - counter≠0 → decrement.
  - counter=0 and PendingCount>0 → ON; PendingCount−1, unless PulseIn=1 on the same edge, in which case PendingCount is unchanged.
  - counter=0, PendingCount=0 and PulseIn=1 → ON directly; PendingCount unchanged.
  - Otherwise → IDLE.
- **PulseIn handling in ON, or in GAP when not consumed as above:**
  - PendingCount<max → PendingCount+1.
  - PendingCount=max → event dropped; Overflow=1.
- Overflow clears only on ClearOverflow=1 or reset. If a drop and ClearOverflow occur on the same edge, Overflow=1 (the set wins).
- LevelOut=1 exactly when state=ON. Busy=1 exactly when state≠IDLE. Both are derived from registered state, so no combinational path runs from PulseIn.

## Timing
- Latency: PulseIn sampled high at edge k in IDLE → LevelOut=1 after edge k, for exactly ON_CYCLES cycles, falling after edge k+ON_CYCLES.
- Gap: LevelOut stays low for at least GAP_CYCLES cycles between output pulses. With a queued event, the next rise follows exactly GAP_CYCLES cycles after the fall.
- Busy spans ON_CYCLES+GAP_CYCLES cycles per isolated event. It is continuous across back-to-back replays.
- PendingCount updates on the same edge that samples PulseIn.
- Reset asserted mid-ON or mid-GAP: LevelOut, Busy and PendingCount go to 0 asynchronously, without waiting for a clock edge. Queued events are discarded.
- First edge after RST_N deasserts behaves as IDLE.

## Test plan
- **Single pulse** (ON=4, GAP=2), PulseIn high 1 cycle at edge 10 → LevelOut high after edges 10–13, low from edge 14; Busy high 6 cycles; PendingCount stays 0.
- **Three consecutive PulseIn cycles** at edges 10, 11, 12 → PendingCount 1, 2 after edges 11, 12. Three LevelOut pulses of 4 cycles each, separated by 2 low cycles; PendingCount decrements to 1, then 0, at each replay start. Busy continuous for 18 cycles.
- **Overflow** (PEND_W=2, max 3), PulseIn high 5 cycles → PendingCount saturates at 3; Overflow=1 after the 5th edge; exactly 4 output pulses appear.
- **Simultaneous consume and arrive**: PendingCount=1 and PulseIn=1 on the GAP-exit edge → state ON, PendingCount remains 1; two further output pulses follow.
- **Reset mid-operation**: RST_N low mid-ON with PendingCount=2 → LevelOut, Busy and PendingCount read 0 before the next edge. After release, a single PulseIn produces one normal 4-cycle pulse.
- **Clear versus set**: ClearOverflow=1 on the same edge as a dropped event → Overflow=1. ClearOverflow alone on the next edge → Overflow=0.
